// File: rtl/complex_mult.sv
// Signed complex multiplier: (x1 + j*y1) * (x2 + j*y2) with valid/ready on both sides.
// One shared OP_W x OP_W multiplier, sequenced over four cycles into two accumulators.
module complex_mult #(
   parameter int unsigned OP_W  = 8,
   parameter int unsigned RES_W = 18
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 op_val,
   output logic                 op_rdy,
   input  logic [4*OP_W-1:0]    op_data,
   output logic                 res_val,
   input  logic                 res_rdy,
   output logic [2*RES_W-1:0]   res_data
);

   localparam int unsigned PW = 2 * OP_W;

   typedef enum logic [2:0] {StIdle, StM0, StM1, StM2, StM3, StResult} state_e;

   state_e                    state_q, state_d;
   logic                      op_rdy_q, op_rdy_d;
   logic                      res_val_q, res_val_d;
   logic [2*RES_W-1:0]        res_data_q, res_data_d;
   logic signed [OP_W-1:0]    x1_q, y1_q, x2_q, y2_q;
   logic signed [OP_W-1:0]    x1_d, y1_d, x2_d, y2_d;
   logic signed [RES_W-1:0]   acc_re_q, acc_re_d, acc_im_q, acc_im_d;

   logic signed [OP_W-1:0]    mul_a, mul_b;
   logic signed [PW-1:0]      prod;
   logic signed [RES_W-1:0]   prod_ext, im_sum;

   // Operand pair for the shared multiplier is chosen by the current step.
   always_comb begin
      mul_a = x1_q;
      mul_b = x2_q;
      case (state_q)
         StM0:    begin mul_a = x1_q; mul_b = x2_q; end
         StM1:    begin mul_a = y1_q; mul_b = y2_q; end
         StM2:    begin mul_a = x1_q; mul_b = y2_q; end
         StM3:    begin mul_a = y1_q; mul_b = x2_q; end
         default: begin mul_a = x1_q; mul_b = x2_q; end
      endcase
   end

   assign prod     = PW'(mul_a) * PW'(mul_b);
   assign prod_ext = RES_W'(prod);
   assign im_sum   = acc_im_q + prod_ext;

   always_comb begin
      state_d    = state_q;
      op_rdy_d   = op_rdy_q;
      res_val_d  = res_val_q;
      res_data_d = res_data_q;
      x1_d       = x1_q;
      y1_d       = y1_q;
      x2_d       = x2_q;
      y2_d       = y2_q;
      acc_re_d   = acc_re_q;
      acc_im_d   = acc_im_q;
      case (state_q)
         StIdle: begin
            op_rdy_d = 1'b1;
            if (op_val && op_rdy_q) begin
               {x1_d, y1_d, x2_d, y2_d} = op_data;
               acc_re_d = '0;
               acc_im_d = '0;
               op_rdy_d = 1'b0;
               state_d  = StM0;
            end
         end
         StM0: begin
            acc_re_d = prod_ext;
            state_d  = StM1;
         end
         StM1: begin
            acc_re_d = acc_re_q - prod_ext;
            state_d  = StM2;
         end
         StM2: begin
            acc_im_d = prod_ext;
            state_d  = StM3;
         end
         StM3: begin
            acc_im_d   = im_sum;
            res_data_d = {acc_re_q, im_sum};
            res_val_d  = 1'b1;
            state_d    = StResult;
         end
         StResult: begin
            if (res_rdy) begin
               res_val_d = 1'b0;
               op_rdy_d  = 1'b1;
               state_d   = StIdle;
            end
         end
         default: begin
            state_d   = StIdle;
            op_rdy_d  = 1'b0;
            res_val_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         op_rdy_q   <= 1'b0;
         res_val_q  <= 1'b0;
         res_data_q <= '0;
         x1_q       <= '0;
         y1_q       <= '0;
         x2_q       <= '0;
         y2_q       <= '0;
         acc_re_q   <= '0;
         acc_im_q   <= '0;
      end else begin
         state_q    <= state_d;
         op_rdy_q   <= op_rdy_d;
         res_val_q  <= res_val_d;
         res_data_q <= res_data_d;
         x1_q       <= x1_d;
         y1_q       <= y1_d;
         x2_q       <= x2_d;
         y2_q       <= y2_d;
         acc_re_q   <= acc_re_d;
         acc_im_q   <= acc_im_d;
      end
   end

   assign op_rdy   = op_rdy_q;
   assign res_val  = res_val_q;
   assign res_data = res_data_q;

endmodule

// File: tb/tb_complex_mult.sv
// Self-checking bench for complex_mult: directed vectors, handshake corners and a random soak
// scored against an integer reference of the complex product.
module tb_complex_mult;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        op_val = 1'b0;
   logic        op_rdy;
   logic [31:0] op_data = '0;
   logic        res_val;
   logic        res_rdy = 1'b0;
   logic [35:0] res_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   complex_mult #(.OP_W(8), .RES_W(18)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .op_val   (op_val),
      .op_rdy   (op_rdy),
      .op_data  (op_data),
      .res_val  (res_val),
      .res_rdy  (res_rdy),
      .res_data (res_data)
   );

   typedef struct {int re; int im;} cplx_t;
   typedef struct {logic [31:0] op; int re; int im;} vec_t;

   cplx_t       exp_q[$];
   int          res_count = 0;
   logic        stall_prev = 1'b0;
   logic [35:0] prev_data = '0;

   function automatic cplx_t model(input logic [31:0] w);
      cplx_t r;
      int x1, y1, x2, y2;
      x1 = int'($signed(w[31:24]));
      y1 = int'($signed(w[23:16]));
      x2 = int'($signed(w[15:8]));
      y2 = int'($signed(w[7:0]));
      r.re = x1 * x2 - y1 * y2;
      r.im = x1 * y2 + y1 * x2;
      return r;
   endfunction

   function automatic int get_re(input logic [35:0] d);
      return int'($signed(d[35:18]));
   endfunction

   function automatic int get_im(input logic [35:0] d);
      return int'($signed(d[17:0]));
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard and stall-protocol monitor, sampled mid-cycle ahead of the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev) begin
            check("hold_valid", res_val, 1);
            check("hold_data", res_data, prev_data);
         end
         if (op_val && op_rdy) exp_q.push_back(model(op_data));
         if (res_val && res_rdy) begin
            check("result_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               cplx_t e;
               e = exp_q.pop_front();
               check("sb_re", get_re(res_data), e.re);
               check("sb_im", get_im(res_data), e.im);
            end
            res_count <= res_count + 1;
         end
         stall_prev <= res_val && !res_rdy;
         prev_data  <= res_data;
      end
   end

   task automatic send(input logic [31:0] w);
      int n;
      n = 0;
      while (!op_rdy && n < 100) begin
         tick();
         n++;
      end
      check("send_ready", op_rdy, 1);
      op_val  = 1'b1;
      op_data = w;
      tick();
      op_val  = 1'b0;
      op_data = $urandom;
   endtask

   task automatic wait_res(output int lat);
      lat = 0;
      while (!res_val && lat < 20) begin
         tick();
         lat++;
      end
      check("res_timeout", res_val, 1);
   endtask

   task automatic consume();
      res_rdy = 1'b1;
      tick();
      res_rdy = 1'b0;
      check("consume_val_low", res_val, 0);
      check("consume_op_rdy", op_rdy, 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[4];
      int          lat;
      int          cnt0;
      logic [35:0] saved;
      int          acc_cyc[$];
      int          rise_cyc[$];
      logic        prev_rv;
      int          base;

      vecs[0] = '{32'h02030402, 2, 16};
      vecs[1] = '{32'h80808080, 0, 32768};
      vecs[2] = '{32'h807f8080, 32640, 128};
      vecs[3] = '{32'h7f7f7f80, 32385, -127};

      op_data = $urandom;
      repeat (3) tick();
      check("rst_op_rdy", op_rdy, 0);
      check("rst_res_val", res_val, 0);
      check("rst_res_data", res_data, 0);
      rst_n = 1'b1;
      check("rel_op_rdy_low", op_rdy, 0);
      tick();
      check("rel_op_rdy_high", op_rdy, 1);

      foreach (vecs[i]) begin
         send(vecs[i].op);
         wait_res(lat);
         check("vec_latency", lat, 4);
         check("vec_op_rdy_busy", op_rdy, 0);
         check("vec_re", get_re(res_data), vecs[i].re);
         check("vec_im", get_im(res_data), vecs[i].im);
         if (i == 0) check("vec_raw_data", res_data, 36'h0_0008_0010);
         consume();
      end

      send($urandom);
      wait_res(lat);
      saved = res_data;
      cnt0  = res_count;
      repeat (5) begin
         tick();
         check("bp_valid", res_val, 1);
         check("bp_data", res_data, saved);
         check("bp_op_rdy", op_rdy, 0);
      end
      consume();
      check("bp_one_transfer", res_count, cnt0 + 1);
      tick();
      check("bp_no_dup", res_count, cnt0 + 1);

      op_data = $urandom;
      op_val  = 1'b1;
      res_rdy = 1'b1;
      prev_rv = 1'b0;
      for (int c = 0; c < 30; c++) begin
         logic acc;
         acc = op_val && op_rdy;
         tick();
         if (acc) begin
            acc_cyc.push_back(c);
            op_data = $urandom;
         end
         if (res_val && !prev_rv) rise_cyc.push_back(c);
         prev_rv = res_val;
      end
      op_val = 1'b0;
      repeat (8) tick();
      res_rdy = 1'b0;
      check("tput_accepts", acc_cyc.size(), 5);
      check("tput_rises", rise_cyc.size(), 5);
      for (int i = 1; i < acc_cyc.size(); i++)
         check("tput_spacing", acc_cyc[i] - acc_cyc[i-1], 6);
      for (int i = 0; i < acc_cyc.size() && i < rise_cyc.size(); i++)
         check("tput_latency", rise_cyc[i] - acc_cyc[i], 4);

      send(vecs[0].op);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check("midrst_res_val", res_val, 0);
      check("midrst_op_rdy", op_rdy, 0);
      check("midrst_res_data", res_data, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      send(vecs[1].op);
      wait_res(lat);
      check("midrst_latency", lat, 4);
      check("midrst_re", get_re(res_data), vecs[1].re);
      check("midrst_im", get_im(res_data), vecs[1].im);
      consume();

      base = res_count;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               repeat ($urandom_range(0, 4)) tick();
               send($urandom);
            end
         end
         begin
            automatic int guard = 0;
            while (res_count < base + 1000 && guard < 60000) begin
               res_rdy = ($urandom_range(0, 3) != 0);
               tick();
               guard++;
            end
            res_rdy = 1'b0;
         end
      join
      check("soak_count", res_count - base, 1000);
      check("soak_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
